// File: rtl/aes_pkg.sv
// Shared AES constants: S-box, round constants, key-schedule FSM encoding.
// The S-box table is also used by the round datapath's S-box stage.
package aes_pkg;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  // Single S-box byte lookup.
  function automatic logic [7:0] sbox_byte(input logic [7:0] b);
    sbox_byte = SBOX[b];
  endfunction

  // Round constant for the transition idx -> idx+1; zero past the last round
  // so the unused value at idx 10 never indexes outside the table.
  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    if (idx < LAST_ROUND) begin
      rcon_of = RCON[idx];
    end else begin
      rcon_of = 8'h00;
    end
  endfunction

endpackage

// File: rtl/key_expansion_iter_if.sv
// Cipher-key input channel and round-key output channel of the key schedule.
// master = upstream/downstream environment, slave = key_expansion_iter.
interface key_expansion_iter_if #(
  parameter int DATA_W = 128
);
  logic              key_valid_in;
  logic              key_ready_out;
  logic [DATA_W-1:0] key_in;
  logic              rk_ready_in;
  logic              rk_valid_out;
  logic [DATA_W-1:0] round_key_out;
  logic [3:0]        round_idx_out;
  logic              done_out;

  modport master (
    output key_valid_in, key_in, rk_ready_in,
    input  key_ready_out, rk_valid_out, round_key_out, round_idx_out, done_out
  );

  modport slave (
    input  key_valid_in, key_in, rk_ready_in,
    output key_ready_out, rk_valid_out, round_key_out, round_idx_out, done_out
  );
endinterface

// File: rtl/aes_sbox_word.sv
// Combinational SubWord: AES S-box applied to each byte of a 32-bit word.
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  // Four independent byte lookups through the shared S-box table.
  always_comb begin
    word_out = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      word_out[i*8 +: 8] = sbox_byte(word_in[i*8 +: 8]);
    end
  end

endmodule

// File: rtl/key_expansion_iter.sv
// AES-128 iterative key schedule. Latches one cipher key, then emits round keys
// 0..NUM_ROUNDS one per accepted transfer. Each next key is computed from the
// registered current key and only registered on a transfer, so backpressure
// simply freezes the registers and all outputs come straight from flops.
module key_expansion_iter
  import aes_pkg::*;
#(
  parameter int         DATA_W     = 128,
  parameter logic [3:0] NUM_ROUNDS = LAST_ROUND
) (
  input logic               clk,
  input logic               reset,
  key_expansion_iter_if.slave bus
);

  state_t            state;
  logic [DATA_W-1:0] cur_key;
  logic [3:0]        round_idx;
  logic              rk_valid;
  logic              key_ready;
  logic              done;

  logic [31:0]       rot_word;
  logic [31:0]       sub_word;
  logic [31:0]       t_word;
  logic [31:0]       nw0;
  logic [31:0]       nw1;
  logic [31:0]       nw2;
  logic [31:0]       nw3;
  logic [DATA_W-1:0] next_key;
  logic              transfer;

  // RotWord of w3 (least significant word): {b,c,d,a}.
  assign rot_word = {cur_key[23:0], cur_key[31:24]};

  aes_sbox_word u_sbox (
    .word_in  (rot_word),
    .word_out (sub_word)
  );

  // Next-key XOR chain; w0 sits in the MSBs.
  always_comb begin
    t_word   = sub_word ^ {rcon_of(round_idx), 24'h00_0000};
    nw0      = cur_key[127:96] ^ t_word;
    nw1      = cur_key[95:64]  ^ nw0;
    nw2      = cur_key[63:32]  ^ nw1;
    nw3      = cur_key[31:0]   ^ nw2;
    next_key = {nw0, nw1, nw2, nw3};
  end

  assign transfer = rk_valid & bus.rk_ready_in;

  // Key-schedule FSM with index counter, key register and registered handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_key   <= '0;
      round_idx <= 4'd0;
      rk_valid  <= 1'b0;
      key_ready <= 1'b1;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.key_valid_in) begin
            cur_key   <= bus.key_in;
            round_idx <= 4'd0;
            rk_valid  <= 1'b1;
            key_ready <= 1'b0;
            state     <= EXPAND;
          end else begin
            key_ready <= 1'b1;
          end
        end
        EXPAND: begin
          if (transfer && (round_idx == NUM_ROUNDS)) begin
            // Last key taken: hand control back and pulse done.
            rk_valid  <= 1'b0;
            key_ready <= 1'b1;
            done      <= 1'b1;
            state     <= IDLE;
          end else if (transfer) begin
            cur_key   <= next_key;
            round_idx <= round_idx + 4'd1;
            done      <= 1'b0;
          end else begin
            done      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rk_valid  <= 1'b0;
          key_ready <= 1'b1;
          done      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.key_ready_out = key_ready;
  assign bus.rk_valid_out  = rk_valid;
  assign bus.round_key_out = cur_key;
  assign bus.round_idx_out = round_idx;
  assign bus.done_out      = done;

endmodule
